// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline control logic.
// Contents:
//   OPC_*   : base opcode field values (inst[6:0])
//   RV_NOP  : canonical NOP (addi x0, x0, 0) used for killed fetch slots
//   state_e : hazard controller state encoding (visible on the debug port)
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

endpackage

// File: rtl/inst_class.sv
// Combinational opcode classifier for one instruction word.
// Ports:
//   inst_i      : 32-bit instruction
//   writes_rd_o : instruction writes rd (LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP)
//   uses_rs1_o  : instruction reads rs1 (JALR, BRANCH, LOAD, STORE, OP-IMM, OP)
//   uses_rs2_o  : instruction reads rs2 (BRANCH, STORE, OP)
//   is_mem_o    : data memory access (LOAD, STORE)
//   rs1_o/rs2_o/rd_o : raw register fields
module inst_class
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        writes_rd_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output logic        is_mem_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  logic [6:0] opc;

  assign opc   = inst_i[6:0];
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];
  assign rd_o  = inst_i[11:7];

  // funct3/funct7 do not affect hazard classification
  logic unused_funct;
  assign unused_funct = ^{inst_i[31:25], inst_i[14:12]};

  always_comb begin
    writes_rd_o = 1'b0;
    uses_rs1_o  = 1'b0;
    uses_rs2_o  = 1'b0;
    is_mem_o    = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd_o = 1'b1;
      OPC_JALR, OPC_OPIMM: begin
        writes_rd_o = 1'b1;
        uses_rs1_o  = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OPC_LOAD: begin
        writes_rd_o = 1'b1;
        uses_rs1_o  = 1'b1;
        is_mem_o    = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        is_mem_o   = 1'b1;
      end
      OPC_OP: begin
        writes_rd_o = 1'b1;
        uses_rs1_o  = 1'b1;
        uses_rs2_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller for the three-stage RV32I pipeline.
// Produces operand-forwarding selects, freezes the pipeline while data memory is
// not ready, and sequences the fetch-kill window after a taken control transfer.
// Optional build macro: EX_HAZARD_PERF_CNT_EN adds stall/flush event counters.
// Parameters:
//   FLUSH_CYCLES : slots killed after a taken branch/jump (1..7)
//   NOP          : encoding for killed slots (consumed by the top level)
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   inst_d       : instruction whose operands are in Execute
//   inst_x       : instruction in Writeback
//   br_taken     : taken branch/JAL/JALR resolved for inst_d
//   mem_ready    : data memory can complete the access of inst_x
//   fwd_a, fwd_b : select writeback data for operand A / B
//   stall        : hold PC, Decode and Execute registers
//   flush        : replace instruction entering Decode with NOP
//   state        : debug state (RUN=0, FLUSH=1, MEM_WAIT=2)
//   stall_cnt, flush_cnt : event counters (EX_HAZARD_PERF_CNT_EN only)
module ex_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] NOP          = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_d,
  input  logic [31:0] inst_x,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  state
`ifdef EX_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [2:0] FcntLoad = 3'(FLUSH_CYCLES - 1);

  // NOP only matters to the top level; it lives here to keep one parameter set
  logic unused_nop;
  assign unused_nop = ^NOP;

  logic       d_writes_rd, d_uses_rs1, d_uses_rs2, d_is_mem;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       x_writes_rd, x_uses_rs1, x_uses_rs2, x_is_mem;
  logic [4:0] x_rs1, x_rs2, x_rd;

  inst_class u_class_d (
    .inst_i      (inst_d),
    .writes_rd_o (d_writes_rd),
    .uses_rs1_o  (d_uses_rs1),
    .uses_rs2_o  (d_uses_rs2),
    .is_mem_o    (d_is_mem),
    .rs1_o       (d_rs1),
    .rs2_o       (d_rs2),
    .rd_o        (d_rd)
  );

  inst_class u_class_x (
    .inst_i      (inst_x),
    .writes_rd_o (x_writes_rd),
    .uses_rs1_o  (x_uses_rs1),
    .uses_rs2_o  (x_uses_rs2),
    .is_mem_o    (x_is_mem),
    .rs1_o       (x_rs1),
    .rs2_o       (x_rs2),
    .rd_o        (x_rd)
  );

  logic unused_class;
  assign unused_class = ^{d_writes_rd, d_is_mem, d_rd, x_uses_rs1, x_uses_rs2, x_rs1, x_rs2};

  // Forwarding: x0 is never forwarded; outputs held low during reset
  logic x_wb_valid;
  assign x_wb_valid = x_writes_rd & (x_rd != 5'd0);
  assign fwd_a = rst & d_uses_rs1 & x_wb_valid & (d_rs1 == x_rd);
  assign fwd_b = rst & d_uses_rs2 & x_wb_valid & (d_rs2 == x_rd);

  logic mem_wait;
  assign mem_wait = x_is_mem & ~mem_ready;
  assign stall    = rst & mem_wait;

  state_e     state_q, state_d, state_eff;
  logic [2:0] fcnt_q, fcnt_d;
  logic       flush_c;

  // On the cycle memory becomes ready, MEM_WAIT behaves as the state it resumes
  // into, so the pending flush slot or a new branch is handled without a gap.
  assign state_eff = (state_q == StMemWait) ? ((fcnt_q != 3'd0) ? StFlush : StRun) : state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (mem_wait) begin
      // br_taken is dropped here; the branch is re-presented after unfreeze
      state_d = StMemWait;
    end else begin
      case (state_eff)
        StRun: begin
          state_d = StRun;
          if (br_taken) begin
            fcnt_d  = FcntLoad;
            state_d = (FcntLoad != 3'd0) ? StFlush : StRun;
          end
        end
        StFlush: begin
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = StRun;
          end else begin
            fcnt_d  = fcnt_q - 3'd1;
            state_d = StFlush;
          end
        end
        default: begin
          fcnt_d  = 3'd0;
          state_d = StRun;
        end
      endcase
    end
  end

  always_comb begin
    flush_c = 1'b0;
    if (!mem_wait) begin
      case (state_eff)
        StRun:   flush_c = br_taken;
        StFlush: flush_c = 1'b1;
        default: flush_c = 1'b0;
      endcase
    end
  end

  assign flush = rst & flush_c;
  assign state = state_q;

`ifdef EX_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  localparam logic [31:0] I_NOP     = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADDI_X0 = 32'h0050_0013; // addi x0,x0,5
  localparam logic [31:0] I_ADD_11  = 32'h0010_8133; // add x2,x1,x1
  localparam logic [31:0] I_ADD_00  = 32'h0000_0133; // add x2,x0,x0
  localparam logic [31:0] I_ADD_15  = 32'h0050_8133; // add x2,x1,x5
  localparam logic [31:0] I_SW_15   = 32'h0012_A023; // sw x1,0(x5)
  localparam logic [31:0] I_SW_IMM1 = 32'h0012_A0A3; // sw x1,1(x5): rd field = 1
  localparam logic [31:0] I_LUI     = 32'h0000_8137; // lui x2, rs1 field = 1
  localparam logic [31:0] I_LW_X3   = 32'h0000_A183; // lw x3,0(x1)
  localparam logic [31:0] I_ADD_30  = 32'h0001_8233; // add x4,x3,x0

  typedef struct packed {
    logic        fa;
    logic        fb;
    logic        st;
    logic        fl;
    logic [1:0]  state;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_d = I_NOP;
  logic [31:0] inst_x = I_NOP;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b1;
  logic        fwd_a, fwd_b, stall, flush;
  logic [1:0]  state;
`ifdef EX_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  ex_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .NOP          (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_d    (inst_d),
    .inst_x    (inst_x),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall),
    .flush     (flush),
    .state     (state)
`ifdef EX_HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    mdl_scnt = 0;
  int    mdl_fcnt = 0;

  // One vector per cycle: drive after the rising edge, queue the expectation.
  task automatic step(input string nm, input logic r, input logic [31:0] d,
                      input logic [31:0] x, input logic b, input logic m,
                      input logic efa, input logic efb, input logic est,
                      input logic efl, input logic [1:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    inst_d    = d;
    inst_x    = x;
    br_taken  = b;
    mem_ready = m;
    if (!r) begin
      mdl_scnt = 0;
      mdl_fcnt = 0;
    end
    e.fa    = efa;
    e.fb    = efb;
    e.st    = est;
    e.fl    = efl;
    e.state = es;
    e.scnt  = 32'(mdl_scnt);
    e.fcnt  = 32'(mdl_fcnt);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (r) begin
      mdl_scnt += int'(est);
      mdl_fcnt += int'(efl);
    end
  endtask

  // Monitor: compares on the falling edge, mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({fwd_a, fwd_b, stall, flush, state} !== {e.fa, e.fb, e.st, e.fl, e.state}) begin
          errors++;
          $display("FAIL %s: got fa/fb/stall/flush/state=%b%b%b%b/%0d want %b%b%b%b/%0d",
                   nm, fwd_a, fwd_b, stall, flush, state, e.fa, e.fb, e.st, e.fl, e.state);
        end
`ifdef EX_HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
          errors++;
          $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                   nm, stall_cnt, flush_cnt, e.scnt, e.fcnt);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //    name        rst d          x          br  mr  fa  fb  st  fl  state
    step("rst_fwd",   0, I_ADD_11,  I_ADDI_X1, 0,  1,  0,  0,  0,  0,  0);
    step("rst_stall", 0, I_ADD_11,  I_LW_X3,   1,  0,  0,  0,  0,  0,  0);
    // forwarding patterns
    step("fwd_both",  1, I_ADD_11,  I_ADDI_X1, 0,  1,  1,  1,  0,  0,  0);
    step("fwd_x0",    1, I_ADD_00,  I_ADDI_X0, 0,  1,  0,  0,  0,  0,  0);
    step("fwd_a_only",1, I_ADD_15,  I_ADDI_X1, 0,  1,  1,  0,  0,  0,  0);
    step("fwd_b_st",  1, I_SW_15,   I_ADDI_X1, 0,  1,  0,  1,  0,  0,  0);
    step("fwd_no_wr", 1, I_ADD_11,  I_SW_IMM1, 0,  1,  0,  0,  0,  0,  0);
    step("fwd_lui",   1, I_LUI,     I_ADDI_X1, 0,  1,  0,  0,  0,  0,  0);
    // load stall for 3 cycles; branch during stall is dropped
    step("ld_c1",     1, I_ADD_30,  I_LW_X3,   1,  0,  1,  0,  1,  0,  0);
    step("ld_c2",     1, I_ADD_30,  I_LW_X3,   1,  0,  1,  0,  1,  0,  2);
    step("ld_c3",     1, I_ADD_30,  I_LW_X3,   0,  0,  1,  0,  1,  0,  2);
    step("ld_rdy",    1, I_ADD_30,  I_LW_X3,   0,  1,  1,  0,  0,  0,  2);
    step("ld_run",    1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    // plain flush window; second br_taken ignored
    step("fl_t0",     1, I_NOP,     I_NOP,     1,  1,  0,  0,  0,  1,  0);
    step("fl_t1",     1, I_NOP,     I_NOP,     1,  1,  0,  0,  0,  1,  1);
    step("fl_t2",     1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    step("fl_idle",   1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    // flush interrupted by a 2-cycle memory wait
    step("fs_t0",     1, I_NOP,     I_NOP,     1,  1,  0,  0,  0,  1,  0);
    step("fs_t1",     1, I_NOP,     I_LW_X3,   0,  0,  0,  0,  1,  0,  1);
    step("fs_t2",     1, I_NOP,     I_LW_X3,   0,  0,  0,  0,  1,  0,  2);
    step("fs_t3",     1, I_NOP,     I_LW_X3,   0,  1,  0,  0,  0,  1,  2);
    step("fs_t4",     1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    step("fs_t5",     1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    // branch taken on the cycle memory becomes ready
    step("mb_t0",     1, I_NOP,     I_LW_X3,   0,  0,  0,  0,  1,  0,  0);
    step("mb_t1",     1, I_NOP,     I_LW_X3,   1,  1,  0,  0,  0,  1,  2);
    step("mb_t2",     1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  1,  1);
    step("mb_t3",     1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    // reset mid-flush
    step("rf_t0",     1, I_NOP,     I_NOP,     1,  1,  0,  0,  0,  1,  0);
    step("rf_rst",    0, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    step("rf_run",    1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    step("rf_run2",   1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    // reset mid-stall
    step("rs_t0",     1, I_NOP,     I_LW_X3,   0,  0,  0,  0,  1,  0,  0);
    step("rs_t1",     1, I_NOP,     I_LW_X3,   0,  0,  0,  0,  1,  0,  2);
    step("rs_rst",    0, I_NOP,     I_LW_X3,   0,  0,  0,  0,  0,  0,  0);
    step("rs_run",    1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);
    step("rs_run2",   1, I_NOP,     I_NOP,     0,  1,  0,  0,  0,  0,  0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline control block for the three-stage RV32I core: Fetch/Decode, then Execute, then Writeback. It sits beside the Execute stage.
- Generates operand-forwarding selects for the Execute operand muxes (`Data_A_mux`/`Data_B_mux` sources).
- Freezes the pipeline while data memory/IO is not ready.
- Sequences the fetch-kill (flush) window after a taken control transfer.
- Optionally keeps stall/flush performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: instructions killed after a taken branch/jump; matches synchronous IMEM latency; legal range 1..7.
- `NOP`, 32'h0000_0013: encoding for the killed slot; consumed by the top level.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_d` in 32: instruction whose operands are in Execute this cycle (Decode register).
- `inst_x` in 32: instruction registered out of Execute (Writeback stage).
- `br_taken` in 1: taken branch, JAL or JALR resolved for `inst_d`.
- `mem_ready` in 1: data memory/IO can complete the access of `inst_x`.
- `fwd_a` out 1: 1 selects writeback data for operand A; 0 selects the regfile.
- `fwd_b` out 1: same, for operand B.
- `stall` out 1: hold PC, Decode and Execute registers.
- `flush` out 1: replace the instruction entering Decode with `NOP`.
- `state` out 2: debug encoding, RUN=0, FLUSH=1, MEM_WAIT=2.

## Operation
- Opcode classes:
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - is_mem: LOAD, STORE.
- Forwarding is combinational: `fwd_a` = uses_rs1(`inst_d`) & writes_rd(`inst_x`) & rd(`inst_x`)!=0 & rs1(`inst_d`)==rd(`inst_x`). `fwd_b` is the same using rs2. Both are independent of state and are valid during stall.
- `mem_wait` = is_mem(`inst_x`) & !`mem_ready`. `stall` = `mem_wait` (combinational, same cycle), in every state.
- FSM with a flush counter `fcnt` (3 bits):
  - RUN:
    - If `mem_wait`, go to MEM_WAIT; a simultaneous `br_taken` is ignored because it is re-presented after unfreeze.
    - Else if `br_taken`, assert `flush` combinationally, load `fcnt`=FLUSH_CYCLES-1, and go to FLUSH (or stay in RUN if FLUSH_CYCLES=1).
  - FLUSH:
    - `flush`=1. `br_taken` is ignored because `inst_d` is a bubble.
    - If `mem_wait`, go to MEM_WAIT with `fcnt` held.
    - Else decrement `fcnt`; at `fcnt`==1, return to RUN after this cycle.
  - MEM_WAIT:
    - `stall`=1 while `mem_wait`; `flush`=0.
    - When `mem_ready` rises, return to FLUSH if `fcnt`!=0, else to RUN.
    - `br_taken` is evaluated in that same cycle per RUN rules.
- Total killed slots after a taken transfer is exactly FLUSH_CYCLES, regardless of intervening stalls.

## Timing
- Reset, asynchronous and active-low: state=RUN, `fcnt`=0, counters=0, `stall`=0, `flush`=0. `fwd_a`/`fwd_b` are forced 0 while `rst`=0.
- Forwarding, stall and first-cycle flush have zero latency (combinational from inputs). There is no combinational path from `br_taken` to `stall`.
- Flush window: cycles T..T+FLUSH_CYCLES-1 for `br_taken` at T, extended only by MEM_WAIT cycles.
- Reset deassertion mid-flush or mid-stall resumes in RUN with nothing pending.

## Configuration
- `EX_HAZARD_PERF_CNT_EN`:
  - Defined: adds outputs `stall_cnt` (32) and `flush_cnt` (32). Each increments once per cycle that `stall`/`flush` is 1, wraps at 2^32, and resets to 0.
  - Undefined: the ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP),
  - the state encoding,
  - the `NOP` constant.
- One sub-module, `inst_class`: combinational decode producing writes_rd/uses_rs1/uses_rs2/is_mem plus rs1/rs2/rd fields. It is instantiated twice, once for `inst_d` and once for `inst_x`.

## Test plan
- `inst_x`=0x00500093 (addi x1,x0,5), `inst_d`=0x00108133 (add x2,x1,x1) -> `fwd_a`=1, `fwd_b`=1, `stall`=0.
- `inst_x`=0x00500013 (addi x0,x0,5), `inst_d`=0x00000133 (add x2,x0,x0) -> `fwd_a`=0, `fwd_b`=0 (x0 never forwarded).
- `inst_x`=0x0000a183 (lw x3,0(x1)), `mem_ready`=0 for 3 cycles -> `stall`=1 for exactly those 3 cycles, state=MEM_WAIT, then RUN; `inst_d` using x3 gets `fwd_a`=1 throughout.
- `br_taken` pulse at cycle 10, FLUSH_CYCLES=2 -> `flush`=1 in cycles 10–11, 0 at 12; a `br_taken` at cycle 11 is ignored.
- `br_taken` at cycle 10, then `mem_wait` during cycle 11 for 2 cycles -> `flush`=1 at 10, 0 at 11–12, 1 at 13, 0 at 14.
- With `EX_HAZARD_PERF_CNT_EN`: the previous scenario -> `flush_cnt`=2, `stall_cnt`=2. Asserting `rst`=0 mid-flush -> both counters 0, `flush`=0 immediately.
